// File: rtl/multi_chan_counter.sv
// NUM_CH independent programmable up-counters with one-shot or auto-wrap terminal handling.
// A valid/ready config port loads and controls the channels; rd_ctr gives a registered readback.
//
// state  | meaning
// IDLE   | stopped, ctr holds its value
// RUN    | counting on every cycle with cnt_en high
// DONE   | one-shot terminal reached, ctr holds max
module multi_chan_counter #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cnt_en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_op,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [WIDTH-1:0]  cfg_max,
   input  logic              cfg_wrap,
   output logic              cfg_err,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [WIDTH-1:0]  rd_ctr,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done,
   output logic [NUM_CH-1:0] done_pulse
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   state_t            st      [NUM_CH];
   logic [WIDTH-1:0]  ctr     [NUM_CH];
   logic [WIDTH-1:0]  max_val [NUM_CH];
   logic [NUM_CH-1:0] wrap;

   logic              accept;
   logic              ch_ok;
   logic              err_next;
   logic [NUM_CH-1:0] sel;

   // Channel decode; a select that matches no channel is still accepted but flagged.
   always_comb begin
      accept   = cfg_valid && cfg_ready;
      sel      = '0;
      ch_ok    = 1'b0;
      err_next = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            ch_ok  = 1'b1;
            sel[i] = accept;
            if (cfg_op == OP_RESUME && st[i] == S_DONE) err_next = accept;
         end
      end
      if (!ch_ok) err_next = accept;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st[i]      <= S_IDLE;
            ctr[i]     <= '0;
            max_val[i] <= '0;
         end
         wrap       <= '0;
         done       <= '0;
         done_pulse <= '0;
         cfg_err    <= 1'b0;
         rd_ctr     <= '0;
         cfg_ready  <= 1'b0;
      end else begin
         cfg_ready <= 1'b1;
         cfg_err   <= err_next;
         rd_ctr    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_ctr <= ctr[i];
         end
         for (int i = 0; i < NUM_CH; i++) begin
            done_pulse[i] <= 1'b0;
            // An accepted command wins over counting, which also swallows a coincident terminal pulse.
            if (sel[i]) begin
               case (cfg_op)
                  OP_LOAD: begin
                     ctr[i]     <= '0;
                     max_val[i] <= cfg_max;
                     wrap[i]    <= cfg_wrap;
                     st[i]      <= S_RUN;
                     done[i]    <= 1'b0;
                  end
                  OP_STOP: begin
                     if (st[i] == S_RUN) st[i] <= S_IDLE;
                  end
                  OP_RESUME: begin
                     if (st[i] == S_IDLE) st[i] <= S_RUN;
                  end
                  default: begin
                     done[i] <= 1'b0;
                     if (st[i] == S_DONE) st[i] <= S_IDLE;
                  end
               endcase
            end else if (st[i] == S_RUN && cnt_en) begin
               if (ctr[i] != max_val[i]) begin
                  ctr[i] <= ctr[i] + 1'b1;
               end else begin
                  done[i]       <= 1'b1;
                  done_pulse[i] <= 1'b1;
                  if (wrap[i]) ctr[i] <= '0;
                  else         st[i]  <= S_DONE;
               end
            end
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) busy[i] = (st[i] == S_RUN);
   end

endmodule

// File: tb/tb_multi_chan_counter.sv
// Bench for multi_chan_counter: a default 32-bit/4-channel instance and a 4-bit/3-channel instance.
// Expected readback/pulse pairs are queued as stimulus is issued and popped one per clock.
module tb_multi_chan_counter;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        cnt_en, cfg_valid, cfg_wrap, cfg_ready, cfg_err;
   logic [1:0]  cfg_op, cfg_ch, rd_ch;
   logic [31:0] cfg_max, rd_ctr;
   logic [3:0]  busy, done, done_pulse;

   logic        w_cnt_en, w_cfg_valid, w_cfg_wrap, w_cfg_ready, w_cfg_err;
   logic [1:0]  w_cfg_op, w_cfg_ch, w_rd_ch;
   logic [3:0]  w_cfg_max, w_rd_ctr;
   logic [2:0]  w_busy, w_done, w_done_pulse;

   typedef struct {
      logic [31:0] rd;
      logic        pulse;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   multi_chan_counter dut (
      .clk(clk), .reset(reset), .cnt_en(cnt_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_max(cfg_max), .cfg_wrap(cfg_wrap), .cfg_err(cfg_err),
      .rd_ch(rd_ch), .rd_ctr(rd_ctr), .busy(busy), .done(done), .done_pulse(done_pulse)
   );

   multi_chan_counter #(.WIDTH(4), .NUM_CH(3)) dut_w (
      .clk(clk), .reset(reset), .cnt_en(w_cnt_en), .cfg_valid(w_cfg_valid), .cfg_ready(w_cfg_ready),
      .cfg_op(w_cfg_op), .cfg_ch(w_cfg_ch), .cfg_max(w_cfg_max), .cfg_wrap(w_cfg_wrap), .cfg_err(w_cfg_err),
      .rd_ch(w_rd_ch), .rd_ctr(w_rd_ctr), .busy(w_busy), .done(w_done), .done_pulse(w_done_pulse)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [31:0] mx, input logic wr);
      cfg_valid = 1'b1; cfg_op = op; cfg_ch = ch; cfg_max = mx; cfg_wrap = wr;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wsend(input logic [1:0] op, input logic [1:0] ch, input logic [3:0] mx, input logic wr);
      w_cfg_valid = 1'b1; w_cfg_op = op; w_cfg_ch = ch; w_cfg_max = mx; w_cfg_wrap = wr;
      step();
      w_cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", cfg_ready); end
      total++; if (busy !== 4'h0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
      total++; if (done !== 4'h0) begin bad++; $display("FAIL rst_done got=%h exp=0", done); end
      total++; if (done_pulse !== 4'h0) begin bad++; $display("FAIL rst_pulse got=%h exp=0", done_pulse); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", cfg_err); end
      total++; if (rd_ctr !== 32'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", rd_ctr); end
      reset = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ready_first got=%0b exp=0", cfg_ready); end
      step();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%0b exp=1", cfg_ready); end
   endtask

   task automatic test_one_shot();
      int npulse = 0;
      cnt_en = 1'b1; rd_ch = 2'd0;
      send(OP_LOAD, 2'd0, 32'd3, 1'b0);
      total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL os_busy got=%0b exp=1", busy[0]); end
      for (int k = 0; k < 6; k++) sbq.push_back('{rd: (k < 3) ? 32'(k) : 32'd3, pulse: (k == 3)});
      while (sbq.size() > 0) begin
         step();
         e = sbq.pop_front();
         if (done_pulse[0]) npulse++;
         total++; if (rd_ctr !== e.rd) begin bad++; $display("FAIL os_rd got=%0d exp=%0d", rd_ctr, e.rd); end
         total++; if (done_pulse[0] !== e.pulse) begin bad++; $display("FAIL os_pulse got=%0b exp=%0b", done_pulse[0], e.pulse); end
      end
      total++; if (npulse !== 1) begin bad++; $display("FAIL os_npulse got=%0d exp=1", npulse); end
      total++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL os_end got done=%0b busy=%0b exp done=1 busy=0", done[0], busy[0]); end
   endtask

   task automatic test_wrap();
      rd_ch = 2'd1;
      send(OP_LOAD, 2'd1, 32'd2, 1'b1);
      for (int k = 1; k <= 9; k++) sbq.push_back('{rd: 32'((k - 1) % 3), pulse: (k % 3 == 0)});
      while (sbq.size() > 0) begin
         step();
         e = sbq.pop_front();
         total++; if (rd_ctr !== e.rd) begin bad++; $display("FAIL wrap_rd got=%0d exp=%0d", rd_ctr, e.rd); end
         total++; if (done_pulse[1] !== e.pulse) begin bad++; $display("FAIL wrap_pulse got=%0b exp=%0b", done_pulse[1], e.pulse); end
         total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL wrap_busy got=%0b exp=1", busy[1]); end
      end
   endtask

   task automatic test_pause_stop_resume();
      rd_ch = 2'd2;
      send(OP_LOAD, 2'd2, 32'd10, 1'b0);
      repeat (3) step();
      cnt_en = 1'b0;
      repeat (4) begin
         step();
         total++; if (rd_ctr !== 32'd3) begin bad++; $display("FAIL frz_rd got=%0d exp=3", rd_ctr); end
         total++; if (done_pulse !== 4'h0) begin bad++; $display("FAIL frz_pulse got=%h exp=0", done_pulse); end
      end
      cnt_en = 1'b1;
      repeat (2) step();
      send(OP_STOP, 2'd2, 32'd0, 1'b0);
      repeat (3) begin
         step();
         total++; if (busy[2] !== 1'b0) begin bad++; $display("FAIL stop_busy got=%0b exp=0", busy[2]); end
         total++; if (rd_ctr !== 32'd5) begin bad++; $display("FAIL stop_rd got=%0d exp=5", rd_ctr); end
      end
      send(OP_RESUME, 2'd2, 32'd0, 1'b0);
      total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL res_busy got=%0b exp=1", busy[2]); end
      for (int k = 1; k <= 7; k++) sbq.push_back('{rd: (4 + k < 10) ? 32'(4 + k) : 32'd10, pulse: (k == 6)});
      while (sbq.size() > 0) begin
         step();
         e = sbq.pop_front();
         total++; if (rd_ctr !== e.rd) begin bad++; $display("FAIL res_rd got=%0d exp=%0d", rd_ctr, e.rd); end
         total++; if (done_pulse[2] !== e.pulse) begin bad++; $display("FAIL res_pulse got=%0b exp=%0b", done_pulse[2], e.pulse); end
      end
      total++; if (done[2] !== 1'b1 || busy[2] !== 1'b0) begin bad++; $display("FAIL res_end got done=%0b busy=%0b exp done=1 busy=0", done[2], busy[2]); end
   endtask

   task automatic test_collision();
      rd_ch = 2'd3;
      send(OP_LOAD, 2'd3, 32'd1, 1'b1);
      step();
      step();
      total++; if (done_pulse[3] !== 1'b1 || done[3] !== 1'b1) begin bad++; $display("FAIL col_first got pulse=%0b done=%0b exp 1 1", done_pulse[3], done[3]); end
      step();
      send(OP_LOAD, 2'd3, 32'd5, 1'b0);
      total++; if (done_pulse[3] !== 1'b0) begin bad++; $display("FAIL col_pulse got=%0b exp=0", done_pulse[3]); end
      total++; if (done[3] !== 1'b0 || busy[3] !== 1'b1) begin bad++; $display("FAIL col_state got done=%0b busy=%0b exp done=0 busy=1", done[3], busy[3]); end
      for (int k = 1; k <= 7; k++) sbq.push_back('{rd: (k - 1 < 5) ? 32'(k - 1) : 32'd5, pulse: (k == 6)});
      while (sbq.size() > 0) begin
         step();
         e = sbq.pop_front();
         total++; if (rd_ctr !== e.rd) begin bad++; $display("FAIL col_rd got=%0d exp=%0d", rd_ctr, e.rd); end
         total++; if (done_pulse[3] !== e.pulse) begin bad++; $display("FAIL col_pulse2 got=%0b exp=%0b", done_pulse[3], e.pulse); end
      end
      total++; if (done[3] !== 1'b1) begin bad++; $display("FAIL col_done got=%0b exp=1", done[3]); end
   endtask

   task automatic test_err_clear();
      send(OP_RESUME, 2'd3, 32'd0, 1'b0);
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b exp=1", cfg_err); end
      total++; if (busy[3] !== 1'b0 || done[3] !== 1'b1) begin bad++; $display("FAIL err_state got busy=%0b done=%0b exp busy=0 done=1", busy[3], done[3]); end
      step();
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_once got=%0b exp=0", cfg_err); end
      send(OP_CLEAR, 2'd3, 32'd0, 1'b0);
      total++; if (done[3] !== 1'b0 || busy[3] !== 1'b0) begin bad++; $display("FAIL clr_state got done=%0b busy=%0b exp 0 0", done[3], busy[3]); end
      send(OP_RESUME, 2'd3, 32'd0, 1'b0);
      total++; if (busy[3] !== 1'b1 || cfg_err !== 1'b0) begin bad++; $display("FAIL clr_resume got busy=%0b err=%0b exp busy=1 err=0", busy[3], cfg_err); end
      step();
      total++; if (done_pulse[3] !== 1'b1) begin bad++; $display("FAIL clr_term got=%0b exp=1", done_pulse[3]); end
   endtask

   task automatic test_reset_mid();
      send(OP_LOAD, 2'd0, 32'd100, 1'b0);
      repeat (2) step();
      reset = 1'b1;
      step();
      total++; if (busy !== 4'h0 || done !== 4'h0 || done_pulse !== 4'h0) begin bad++; $display("FAIL mid_flags got busy=%h done=%h pulse=%h exp 0", busy, done, done_pulse); end
      total++; if (cfg_ready !== 1'b0 || cfg_err !== 1'b0 || rd_ctr !== 32'd0) begin bad++; $display("FAIL mid_out got ready=%0b err=%0b rd=%0d exp 0", cfg_ready, cfg_err, rd_ctr); end
      step();
      reset = 1'b0;
      step();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b exp=1", cfg_ready); end
      for (int i = 0; i < 4; i++) begin
         rd_ch = 2'(i);
         step();
         total++; if (rd_ctr !== 32'd0) begin bad++; $display("FAIL mid_ctr ch=%0d got=%0d exp=0", i, rd_ctr); end
      end
      send(OP_RESUME, 2'd0, 32'd0, 1'b0);
      total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL mid_resume got=%0b exp=1", busy[0]); end
      step();
      total++; if (done_pulse[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL mid_max0 got pulse=%0b busy=%0b exp 1 0", done_pulse[0], busy[0]); end
   endtask

   task automatic test_width4();
      w_cnt_en = 1'b1; w_rd_ch = 2'd0;
      wsend(OP_LOAD, 2'd0, 4'd15, 1'b0);
      for (int k = 1; k <= 17; k++) sbq.push_back('{rd: (k - 1 < 15) ? 32'(k - 1) : 32'd15, pulse: (k == 16)});
      while (sbq.size() > 0) begin
         step();
         e = sbq.pop_front();
         total++; if (w_rd_ctr !== e.rd[3:0]) begin bad++; $display("FAIL w4_rd got=%0d exp=%0d", w_rd_ctr, e.rd[3:0]); end
         total++; if (w_done_pulse[0] !== e.pulse) begin bad++; $display("FAIL w4_pulse got=%0b exp=%0b", w_done_pulse[0], e.pulse); end
      end
      total++; if (w_done[0] !== 1'b1 || w_busy[0] !== 1'b0) begin bad++; $display("FAIL w4_end got done=%0b busy=%0b exp 1 0", w_done[0], w_busy[0]); end
      wsend(OP_LOAD, 2'd3, 4'd7, 1'b1);
      total++; if (w_cfg_err !== 1'b1 || w_busy !== 3'b000) begin bad++; $display("FAIL w4_oor got err=%0b busy=%b exp err=1 busy=000", w_cfg_err, w_busy); end
      w_rd_ch = 2'd3;
      step();
      total++; if (w_rd_ctr !== 4'd0 || w_cfg_err !== 1'b0) begin bad++; $display("FAIL w4_oor_rd got rd=%0d err=%0b exp 0 0", w_rd_ctr, w_cfg_err); end
      wsend(OP_LOAD, 2'd1, 4'd0, 1'b1);
      repeat (3) begin
         step();
         total++; if (w_done_pulse[1] !== 1'b1 || w_busy[1] !== 1'b1) begin bad++; $display("FAIL w4_max0 got pulse=%0b busy=%0b exp 1 1", w_done_pulse[1], w_busy[1]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; cnt_en = 1'b0; cfg_valid = 1'b0; cfg_op = 2'b00; cfg_ch = 2'd0;
      cfg_max = 32'd0; cfg_wrap = 1'b0; rd_ch = 2'd0;
      w_cnt_en = 1'b0; w_cfg_valid = 1'b0; w_cfg_op = 2'b00; w_cfg_ch = 2'd0;
      w_cfg_max = 4'd0; w_cfg_wrap = 1'b0; w_rd_ch = 2'd0;
      test_reset();
      test_one_shot();
      test_wrap();
      test_pause_stop_resume();
      test_collision();
      test_err_clear();
      test_reset_mid();
      test_width4();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_chan_counter.md
Name: multi_chan_counter

Overview:
- Parametrised successor to the single free-running terminal-count block.
- Provides NUM_CH independent up-counters, each with a runtime-programmable terminal value and a one-shot or auto-wrap mode.
- A valid/ready config port loads and controls the channels; per-channel sticky done flags and one-cycle terminal pulses are reported.
- Sits between the testbench/SST-side control path and model logic needing multiple programmable timers.

Parameters:
- WIDTH, 32, counter and terminal-value width in bits (>=2).
- NUM_CH, 4, number of independent channels (1..16).
- CH_W, max($clog2(NUM_CH),1), channel-select width (derived, not overridden).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cnt_en  in  1  global count enable; running channels advance only when high.
- cfg_valid  in  1  config command valid.
- cfg_ready  out  1  config command accepted when valid&&ready.
- cfg_op  in  2  00 LOAD_START, 01 STOP, 10 RESUME, 11 CLEAR_DONE.
- cfg_ch  in  CH_W  target channel.
- cfg_max  in  WIDTH  terminal value (LOAD_START only).
- cfg_wrap  in  1  1=auto-wrap, 0=one-shot (LOAD_START only).
- cfg_err  out  1  one-cycle pulse: accepted command had cfg_ch>=NUM_CH, or RESUME on a DONE channel.
- rd_ch  in  CH_W  readback channel select.
- rd_ctr  out  WIDTH  registered count of channel rd_ch; 1-cycle latency.
- busy  out  NUM_CH  channel in RUN.
- done  out  NUM_CH  sticky terminal-reached flag.
- done_pulse  out  NUM_CH  one-cycle pulse on each terminal event.

Behaviour:
- Reset (held any number of cycles, mid-operation included):
  - all ctr=0, max=0, wrap=0, state IDLE;
  - busy=0, done=0, done_pulse=0, cfg_err=0, rd_ctr=0, cfg_ready=0.
- cfg_ready is registered !reset: low during reset and the first cycle after, then held high.
- Per-channel FSM states: IDLE, RUN, DONE.
- LOAD_START:
  - next cycle: ctr=0, max/wrap latched, state RUN, done cleared, from any state.
  - First increment occurs on the following enabled cycle.
- STOP: RUN->IDLE, ctr held. No effect in IDLE or DONE.
- RESUME: IDLE->RUN, ctr and max kept. On a DONE channel: no state change, cfg_err pulse.
- CLEAR_DONE: done[ch]=0 and DONE->IDLE. ctr holds its value.
- RUN with cnt_en=1:
  - ctr!=max: ctr<=ctr+1.
  - ctr==max, one-shot: ctr holds max, ->DONE, done=1, done_pulse=1.
  - ctr==max, wrap: ctr<=0, stays RUN, done=1, done_pulse=1 for that cycle only.
- cnt_en=0: all counters freeze; no pulses.
- max=0:
  - one-shot: terminal on the first enabled cycle in RUN.
  - wrap: done_pulse every enabled cycle.
- Arithmetic is modulo 2^WIDTH. max=2^WIDTH-1 reaches terminal without overflow before compare.
- Cfg vs terminal collision: an accepted command to a channel in the same cycle as its terminal event takes priority, and done_pulse is suppressed. Other channels are unaffected.
- Out-of-range cfg_ch: command accepted (handshake completes), no state change, cfg_err pulses the next cycle.
- busy/done/done_pulse are registered; all change one cycle after the causing edge condition.
- rd_ctr shows ctr as of the previous edge for rd_ch. rd_ch>=NUM_CH returns 0.

Test Plan:
- Reset, then LOAD_START ch0 max=3 one-shot, cnt_en=1 -> cfg_ready rises 1 cycle after reset release; ctr 0,1,2,3; done_pulse[0] exactly once; done[0]=1, busy[0]=0, ctr stays 3.
- LOAD_START ch1 max=2 wrap, 9 enabled cycles -> rd_ctr sequence 0,1,2,0,1,2,0,1,2; done_pulse[1] every 3rd cycle; busy[1] stays 1.
- ch2 max=10 running, toggle cnt_en low 4 cycles, STOP at ctr=5, RESUME -> ctr frozen while disabled; holds 5 in IDLE; reaches done after 5 more enabled cycles.
- ch3 wrap max=1: issue LOAD_START max=5 on the exact terminal cycle -> no done_pulse that cycle; ctr=0, max=5, done[3]=0.
- NUM_CH=4: cfg_ch=3 RESUME while DONE, then reset asserted mid-run on all channels -> cfg_err pulse once; after reset, all outputs 0 and ctr=0.
- WIDTH=4, max=15 one-shot -> 16 counts, done set at 15, no wrap to 0.
